game_ctrl: RTL and testbench
============================

# game_ctrl

Top-level sequencer for the drop-catch game datapath. It owns the game life cycle (idle, reset, run, pause, game over) and generates the periodic `e_act` step pulse. It converts raw left/right button levels into one-shot moves delivered on each step, and keeps the score. It drives the datapath's synchronous reset/enable/move inputs and observes its `dead` flag.

## Interface
- `TICK_DIV`, default 1000000: clock cycles per game step; must be ≥2.
- `RST_CYCLES`, default 2: cycles `game_rst_o` is held high per restart; must be ≥1.
- `OVER_TICKS`, default 64: steps the game-over state lasts before returning to idle; must be ≥1.
- `clk_i` input 1: single clock, all logic on rising edge.
- `reset_ni` input 1: asynchronous, active-low reset.
- `start_i` input 1: start/restart button level.
- `pause_i` input 1: pause toggle button level.
- `right_i` input 1: right button level.
- `left_i` input 1: left button level.
- `dead_i` input 1: datapath dead flag.
- `game_rst_o` output 1: synchronous active-high reset to the datapath.
- `e_act_o` output 1: one-cycle step pulse to the datapath.
- `right_o` output 1: move right, valid only with `e_act_o`.
- `left_o` output 1: move left, valid only with `e_act_o`.
- `state_o` output 3: current state (IDLE=0, RESET=1, RUN=2, PAUSE=3, OVER=4).
- `score_o` output 16: steps survived in the current game.
- `best_o` output 16: highest final score since power-up/reset.

## Operation
- Edge detection: each button input is registered once. "Press" means the cycle in which the registered value is 1 and its previous value was 0. The resulting one-cycle latency is intentional.
- IDLE: divider is held at 0. A `start` press moves to RESET.
- RESET: `game_rst_o`=1 for exactly RST_CYCLES cycles. Score, divider and pending moves are cleared. The state then moves to RUN. All presses are ignored in this state.
- RUN: the divider counts from 0 to TICK_DIV-1 and wraps. When the count equals TICK_DIV-1, `e_act_o`=1 for that cycle and `score_o` increments, saturating at 0xFFFF.
- RUN priority, highest first:
  1. `start` press: go to RESET.
  2. `dead_i`=1: go to OVER. No `e_act_o` is issued that cycle. `best_o` is set to max(`best_o`, `score_o`).
  3. `pause` press: go to PAUSE.
  4. Otherwise, normal stepping.
- Move handling:
  - A right/left press sets a pending flag for that direction.
  - On `e_act_o`, `right_o`/`left_o` equal the pending flags, and both flags are then cleared.
  - If both flags are pending at the step, both outputs are 0 and both flags clear.
  - A press landing in the same cycle as `e_act_o` is not delivered on that step. It sets its flag for the next step.
  - Repeated presses of the same direction before a step collapse to one move.
- PAUSE: the divider is frozen at its current value and no `e_act_o` is issued. Pending moves are cleared on entry.
  - A `pause` press returns to RUN, and counting resumes from the frozen value.
  - A `start` press goes to RESET.
  - `dead_i` is ignored.
- OVER: the divider keeps running with `e_act_o` forced to 0. A step counter counts divider wraps. After OVER_TICKS wraps the state moves to IDLE. Presses are ignored.
- Divider width is clog2(TICK_DIV). The OVER counter width is clog2(OVER_TICKS+1).

## Timing
- Async reset values: state IDLE, `game_rst_o`=0, `e_act_o`=0, `right_o`=0, `left_o`=0, `score_o`=0, `best_o`=0. Divider, counters, edge registers and pending flags are all 0.
- Reset assertion mid-game returns to IDLE immediately, regardless of edges. Deassertion is synchronised by the user.
- All outputs are registered. A button level change appears as a press 2 cycles later.
- `start` press to `game_rst_o` rising: 1 cycle. `game_rst_o` falling to first `e_act_o`: TICK_DIV cycles.
- `e_act_o` period in RUN is exactly TICK_DIV cycles, except after a pause, where the remaining count is preserved.
- Transition from `dead_i` high to `state_o`=OVER: 1 cycle.

## Test plan
Parameters for all scenarios: TICK_DIV=4, RST_CYCLES=2, OVER_TICKS=3.
- Reset, then start pulse -> `game_rst_o` high exactly 2 cycles; `e_act_o` pulses every 4 cycles; `score_o` counts 1,2,3…
- In RUN: right pressed once, then left and right both pressed before the following step -> first step has `right_o`=1 and `left_o`=0; next step has both 0.
- Right press timed to the same cycle as `e_act_o` -> `right_o`=0 on that step and 1 on the next.
- Pause after 1 divider count, hold 20 cycles, pause again -> no `e_act_o` during pause; next `e_act_o` comes 3 cycles after resume; score unchanged during pause.
- `dead_i` asserted with score 5 in the same cycle as a would-be step -> no `e_act_o`, OVER with `best_o`=5, IDLE after 12 cycles; start pressed during OVER is ignored.
- `dead_i` and a `start` press in the same cycle -> RESET (`score_o`=0); `reset_ni` low mid-RUN -> all outputs 0 and IDLE immediately, `best_o`=0.

Source files
------------

// File: rtl/game_ctrl.sv
// game_ctrl: life-cycle sequencer for the drop-catch game; generates the step pulse,
// latches one-shot moves per step and tracks the current and best scores.
module game_ctrl #(
  parameter int TICK_DIV   = 1000000,
  parameter int RST_CYCLES = 2,
  parameter int OVER_TICKS = 64
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic        pause_i,
  input  logic        right_i,
  input  logic        left_i,
  input  logic        dead_i,
  output logic        game_rst_o,
  output logic        e_act_o,
  output logic        right_o,
  output logic        left_o,
  output logic [2:0]  state_o,
  output logic [15:0] score_o,
  output logic [15:0] best_o
);
  localparam int DW = $clog2(TICK_DIV);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int OW = $clog2(OVER_TICKS + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
  localparam logic [RW-1:0] RST_MAX = RW'(RST_CYCLES - 1);
  localparam logic [OW-1:0] OVR_MAX = OW'(OVER_TICKS - 1);

  typedef enum logic [2:0] {IDLE = 3'd0, RESET = 3'd1, RUN = 3'd2, PAUSE = 3'd3, OVER = 3'd4} state_e;

  state_e        state_q, state_d;
  logic [3:0]    btn_q, prev_q, press;
  logic [DW-1:0] div_q, div_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [OW-1:0] ocnt_q, ocnt_d;
  logic          pr_q, pr_d, pl_q, pl_d;
  logic          game_rst_q, game_rst_d, e_act_q, e_act_d, right_q, right_d, left_q, left_d;
  logic [15:0]   score_q, score_d, best_q, best_d;
  logic          wrap, clr, step, keep;

  // press bits: {start, pause, right, left}
  assign press = btn_q & ~prev_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      btn_q      <= '0;
      prev_q     <= '0;
      div_q      <= '0;
      rcnt_q     <= '0;
      ocnt_q     <= '0;
      pr_q       <= 1'b0;
      pl_q       <= 1'b0;
      game_rst_q <= 1'b0;
      e_act_q    <= 1'b0;
      right_q    <= 1'b0;
      left_q     <= 1'b0;
      score_q    <= '0;
      best_q     <= '0;
    end else begin
      state_q    <= state_d;
      btn_q      <= {start_i, pause_i, right_i, left_i};
      prev_q     <= btn_q;
      div_q      <= div_d;
      rcnt_q     <= rcnt_d;
      ocnt_q     <= ocnt_d;
      pr_q       <= pr_d;
      pl_q       <= pl_d;
      game_rst_q <= game_rst_d;
      e_act_q    <= e_act_d;
      right_q    <= right_d;
      left_q     <= left_d;
      score_q    <= score_d;
      best_q     <= best_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = press[3] ? RESET : IDLE;
      RESET:   state_d = (rcnt_q == RST_MAX) ? RUN : RESET;
      RUN:     state_d = press[3] ? RESET : dead_i ? OVER : press[2] ? PAUSE : RUN;
      PAUSE:   state_d = press[3] ? RESET : press[2] ? RUN : PAUSE;
      OVER:    state_d = (wrap && ocnt_q == OVR_MAX) ? IDLE : OVER;
      default: state_d = IDLE;
    endcase
  end

  // A step is only issued while RUN persists, so start/dead/pause all suppress it.
  always_comb begin
    wrap       = div_q == DIV_MAX;
    clr        = state_d == RESET;
    step       = state_q == RUN && state_d == RUN && wrap;
    keep       = (state_q == RUN || state_q == PAUSE) && state_d == RUN;
    div_d      = (clr || state_q == IDLE || state_q == RESET) ? '0 :
                 (state_q == PAUSE || state_d == PAUSE) ? div_q :
                 wrap ? '0 : div_q + 1'b1;
    rcnt_d     = (state_q == RESET && state_d == RESET) ? rcnt_q + 1'b1 : '0;
    ocnt_d     = (state_q == OVER && state_d == OVER) ? ocnt_q + OW'(wrap) : '0;
    pr_d       = keep && (press[1] || (pr_q && !step));
    pl_d       = keep && (press[0] || (pl_q && !step));
    game_rst_d = clr;
    e_act_d    = step;
    right_d    = step && pr_q && !pl_q;
    left_d     = step && pl_q && !pr_q;
    score_d    = clr ? '0 : (step && score_q != 16'hFFFF) ? score_q + 16'd1 : score_q;
    best_d     = (state_q == RUN && state_d == OVER && score_q > best_q) ? score_q : best_q;
  end

  assign state_o    = state_q;
  assign game_rst_o = game_rst_q;
  assign e_act_o    = e_act_q;
  assign right_o    = right_q;
  assign left_o     = left_q;
  assign score_o    = score_q;
  assign best_o     = best_q;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: table-driven move vectors plus hand sequences for reset, pause,
// game-over and priority corners; step outputs checked through a scoreboard queue.
module tb_game_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start_i = 1'b0, pause_i = 1'b0, right_i = 1'b0, left_i = 1'b0, dead_i = 1'b0;
  logic        game_rst_o, e_act_o, right_o, left_o;
  logic [2:0]  state_o;
  logic [15:0] score_o, best_o;

  int vec_n = 0, mis_n = 0;

  typedef struct packed {logic r; logic l; logic [15:0] score;} exp_t;
  typedef struct {int dly; logic r; logic l; logic er; logic el;} vec_t;
  exp_t sb_q[$];
  exp_t got_e;
  vec_t vt[8];

  game_ctrl #(.TICK_DIV(4), .RST_CYCLES(2), .OVER_TICKS(3)) dut (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start_i), .pause_i(pause_i),
    .right_i(right_i), .left_i(left_i), .dead_i(dead_i),
    .game_rst_o(game_rst_o), .e_act_o(e_act_o), .right_o(right_o), .left_o(left_o),
    .state_o(state_o), .score_o(score_o), .best_o(best_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && e_act_o) begin
      vec_n++;
      if (sb_q.size() == 0) begin
        mis_n++;
        $display("FAIL step_unexpected got r=%0b l=%0b score=%0d required no step", right_o, left_o, score_o);
      end else begin
        got_e = sb_q.pop_front();
        if ({right_o, left_o, score_o} !== got_e) begin
          mis_n++;
          $display("FAIL step got r=%0b l=%0b score=%0d required r=%0b l=%0b score=%0d",
                   right_o, left_o, score_o, got_e.r, got_e.l, got_e.score);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    vec_n++;
    if (got !== exp) begin
      mis_n++;
      $display("FAIL %s got=%0d required=%0d", nm, got, exp);
    end
  endtask

  task automatic wait_eact(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!e_act_o && n < 40);
    chk("eact_seen", {15'd0, e_act_o}, 16'd1);
  endtask

  task automatic wait_state(input logic [2:0] s);
    int n = 0;
    while (state_o !== s && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("state_wait", {13'd0, state_o}, {13'd0, s});
  endtask

  initial begin
    int n, cnt;
    logic [15:0] sc;
    vt[0] = '{0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[1] = '{0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[3] = '{2, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[4] = '{0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[5] = '{0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6] = '{2, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[7] = '{0, 1'b0, 1'b0, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_state", {13'd0, state_o}, 16'd0);
    chk("rst_outs", {12'd0, game_rst_o, e_act_o, right_o, left_o}, 16'd0);
    chk("rst_score", score_o, 16'd0);
    chk("rst_best", best_o, 16'd0);
    rst_n = 1'b1;

    // start: game_rst high for exactly two cycles, then steps every 4 cycles
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("grst_lat", {15'd0, game_rst_o}, 16'd0);
    @(negedge clk);
    chk("grst_1", {15'd0, game_rst_o}, 16'd1);
    chk("state_reset", {13'd0, state_o}, 16'd1);
    @(negedge clk);
    chk("grst_2", {15'd0, game_rst_o}, 16'd1);
    @(negedge clk);
    chk("grst_fall", {15'd0, game_rst_o}, 16'd0);
    chk("state_run", {13'd0, state_o}, 16'd2);
    sc = 16'd0;
    for (int i = 0; i < 3; i++) begin
      sc++;
      sb_q.push_back('{1'b0, 1'b0, sc});
      wait_eact(n);
      chk("step_period", 16'(n), 16'd4);
    end

    // move vectors, each aligned to the cycle of the preceding step
    foreach (vt[i]) begin
      repeat (vt[i].dly) @(negedge clk);
      right_i = vt[i].r;
      left_i  = vt[i].l;
      @(negedge clk);
      right_i = 1'b0;
      left_i  = 1'b0;
      sc++;
      sb_q.push_back('{vt[i].er, vt[i].el, sc});
      wait_eact(n);
    end

    // pause after one divider count with a right press that must be dropped
    pause_i = 1'b1;
    right_i = 1'b1;
    @(negedge clk);
    pause_i = 1'b0;
    right_i = 1'b0;
    @(negedge clk);
    chk("state_pause", {13'd0, state_o}, 16'd3);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (e_act_o) cnt++;
    end
    chk("pause_no_step", 16'(cnt), 16'd0);
    chk("pause_score", score_o, sc);
    pause_i = 1'b1;
    @(negedge clk);
    pause_i = 1'b0;
    wait_state(3'd2);
    sc++;
    sb_q.push_back('{1'b0, 1'b0, sc});
    wait_eact(n);
    chk("resume_lat", 16'(n), 16'd3);

    // restart, survive five steps, then die on a would-be step
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 1; i <= 5; i++) sb_q.push_back('{1'b0, 1'b0, 16'(i)});
    for (int i = 0; i < 5; i++) wait_eact(n);
    repeat (3) @(negedge clk);
    dead_i = 1'b1;
    @(negedge clk);
    dead_i = 1'b0;
    chk("dead_no_step", {15'd0, e_act_o}, 16'd0);
    chk("state_over", {13'd0, state_o}, 16'd4);
    chk("best_5", best_o, 16'd5);
    chk("over_score", score_o, 16'd5);
    start_i = 1'b1;
    n = 0;
    while (state_o == 3'd4 && n < 40) begin
      n++;
      @(negedge clk);
      start_i = 1'b0;
    end
    chk("over_len", 16'(n), 16'd12);
    repeat (3) @(negedge clk);
    chk("over_to_idle", {13'd0, state_o}, 16'd0);

    // start press and dead in the same cycle: start wins
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_state(3'd2);
    sb_q.push_back('{1'b0, 1'b0, 16'd1});
    wait_eact(n);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    dead_i  = 1'b1;
    @(negedge clk);
    dead_i  = 1'b0;
    chk("prio_state", {13'd0, state_o}, 16'd1);
    chk("prio_score", score_o, 16'd0);
    chk("prio_best", best_o, 16'd5);
    chk("prio_grst", {15'd0, game_rst_o}, 16'd1);

    // asynchronous reset mid-run
    wait_state(3'd2);
    sb_q.push_back('{1'b0, 1'b0, 16'd1});
    wait_eact(n);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_state", {13'd0, state_o}, 16'd0);
    chk("arst_outs", {12'd0, game_rst_o, e_act_o, right_o, left_o}, 16'd0);
    chk("arst_score", score_o, 16'd0);
    chk("arst_best", best_o, 16'd0);
    chk("sb_drained", 16'(sb_q.size()), 16'd0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, mis_n);
    $finish;
  end
endmodule
